// File: rtl/uart_fifo_bridge.sv
// Byte-level buffering between the uart core and the host register file:
// an RX FIFO fed by the core's ack handshake and a TX FIFO drained into the transmitter.
module uart_fifo_bridge #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            uart_rx_data,
   input  logic                  uart_rx_avail,
   input  logic                  uart_rx_error,
   output logic                  uart_rx_ack,
   output logic [7:0]            uart_tx_data,
   output logic                  uart_tx_wr,
   input  logic                  uart_tx_busy,
   input  logic                  rd_en,
   output logic [7:0]            rd_data,
   output logic                  rx_empty,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic                  rx_overrun,
   output logic                  rx_frame_err,
   input  logic                  err_clr,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  tx_full,
   output logic [DEPTH_LOG2:0]   tx_count
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   typedef enum logic {RX_IDLE, RX_DRAIN} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_WAIT} tx_state_t;

   rx_state_t rx_state, rx_state_nxt;
   tx_state_t tx_state, tx_state_nxt;

   logic [7:0]            rx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [DEPTH_LOG2:0]   rx_cnt;
   logic                  rx_full, rx_push, rx_pop;
   logic                  rx_ack_nxt, ovr_set, frm_set;

   logic [7:0]            tx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [DEPTH_LOG2:0]   tx_cnt;
   logic                  tx_empty, tx_push, tx_pop;
   logic                  tx_wr_nxt;

   // ---------------- RX path ----------------
   assign rx_full  = (rx_cnt == CNT_FULL);
   assign rx_empty = (rx_cnt == '0);
   assign rx_pop   = rd_en && !rx_empty;
   assign rx_count = rx_cnt;
   assign rd_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state    <= RX_IDLE;
         uart_rx_ack <= 1'b0;
      end else begin
         rx_state    <= rx_state_nxt;
         uart_rx_ack <= rx_ack_nxt;
      end
   end

   // DRAIN holds off until the core withdraws its request so one byte is never pushed twice
   always_comb begin
      rx_state_nxt = rx_state;
      rx_ack_nxt   = 1'b0;
      rx_push      = 1'b0;
      ovr_set      = 1'b0;
      frm_set      = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (uart_rx_avail || uart_rx_error) begin
               rx_ack_nxt   = 1'b1;
               rx_state_nxt = RX_DRAIN;
               if (uart_rx_avail) begin
                  if (!rx_full || rx_pop) rx_push = 1'b1;
                  else                    ovr_set = 1'b1;
               end
               if (uart_rx_error) frm_set = 1'b1;
            end
         end
         RX_DRAIN: begin
            if (!uart_rx_avail && !uart_rx_error) rx_state_nxt = RX_IDLE;
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_cnt    <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
            2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         if (ovr_set)      rx_overrun <= 1'b1;
         else if (err_clr) rx_overrun <= 1'b0;
         if (frm_set)      rx_frame_err <= 1'b1;
         else if (err_clr) rx_frame_err <= 1'b0;
      end
   end

   // ---------------- TX path ----------------
   assign tx_full  = (tx_cnt == CNT_FULL);
   assign tx_empty = (tx_cnt == '0);
   assign tx_push  = wr_en && (!tx_full || tx_pop);
   assign tx_count = tx_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state     <= TX_IDLE;
         uart_tx_wr   <= 1'b0;
         uart_tx_data <= '0;
      end else begin
         tx_state   <= tx_state_nxt;
         uart_tx_wr <= tx_wr_nxt;
         if (tx_pop) uart_tx_data <= tx_mem[tx_rd_ptr];
      end
   end

   always_comb begin
      tx_state_nxt = tx_state;
      tx_wr_nxt    = 1'b0;
      tx_pop       = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!tx_empty && !uart_tx_busy) begin
               tx_pop       = 1'b1;
               tx_wr_nxt    = 1'b1;
               tx_state_nxt = TX_STROBE;
            end
         end
         TX_STROBE: tx_state_nxt = TX_WAIT;
         TX_WAIT: begin
            if (!uart_tx_busy) tx_state_nxt = TX_IDLE;
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // When full, a same-cycle push lands in the slot being popped; the pop reads the old value
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_cnt    <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
            2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

endmodule
